// File: rtl/seq_multiplier.sv
// Unsigned shift-and-add sequential multiplier. One iteration per clock
// through a single width-bit ripple-carry adder (fullAdder).
//
// Ports:
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset
//   start  request, accepted only while ready=1
//   A, B   multiplicand / multiplier, captured on an accepted start
//   ready  high in IDLE or DONE
//   busy   high in BUSY
//   done   one-cycle pulse while in DONE
//   P      2*width product, holds until the next accepted start

// Width-bit ripple-carry adder.
module fullAdder #(
  parameter int unsigned width = 64
) (
  input  logic [width-1:0] A,
  input  logic [width-1:0] B,
  input  logic             Cin,
  output logic [width-1:0] S,
  output logic             Cout
);

  // Carry rippled through a block-local variable, LSB to MSB.
  always_comb begin : ripple
    logic cy;
    cy = Cin;
    S  = '0;
    for (int i = 0; i < int'(width); i++) begin
      S[i] = A[i] ^ B[i] ^ cy;
      cy   = (A[i] & B[i]) | (cy & (A[i] ^ B[i]));
    end
    Cout = cy;
  end

endmodule

module seq_multiplier #(
  parameter int unsigned width = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [width-1:0]     A,
  input  logic [width-1:0]     B,
  output logic                 ready,
  output logic                 busy,
  output logic                 done,
  output logic [2*width-1:0]   P
);

  localparam int unsigned cw = $clog2(width);

  typedef enum logic [1:0] {
    st_idle = 2'd0,
    st_busy = 2'd1,
    st_done = 2'd2
  } state_t;

  state_t           state, state_nx;
  logic             accept;
  logic [cw-1:0]    cnt;
  logic [width-1:0] mcand;
  logic [width-1:0] add_b;
  logic [width-1:0] sum;
  logic             cout;

  // Add mcand into the upper half only when the current multiplier LSB is set.
  assign add_b = P[0] ? mcand : '0;

  fullAdder #(.width(width)) u_add (
    .A    (P[2*width-1:width]),
    .B    (add_b),
    .Cin  (1'b0),
    .S    (sum),
    .Cout (cout)
  );

  // Next-state and start acceptance.
  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    case (state)
      st_idle: begin
        if (start) begin
          state_nx = st_busy;
          accept   = 1'b1;
        end
      end
      st_busy: begin
        if (cnt == cw'(width - 1)) state_nx = st_done;
      end
      st_done: begin
        if (start) begin
          state_nx = st_busy;
          accept   = 1'b1;
        end else begin
          state_nx = st_idle;
        end
      end
      default: state_nx = st_idle;
    endcase
  end

  // State, datapath and status flags; status is registered from next state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= st_idle;
      cnt   <= '0;
      mcand <= '0;
      P     <= '0;
      ready <= 1'b1;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nx;
      ready <= (state_nx != st_busy);
      busy  <= (state_nx == st_busy);
      done  <= (state_nx == st_done);
      if (accept) begin
        mcand <= A;
        P     <= {{width{1'b0}}, B};
        cnt   <= '0;
      end else if (state == st_busy) begin
        // Carry-out lands in the top bit, so nothing is ever lost.
        P   <= {cout, sum, P[width-1:1]};
        cnt <= cnt + cw'(1);
      end
    end
  end

endmodule

// File: tb/tb_seq_multiplier.sv
// Directed bench for seq_multiplier at width=8 and width=64.
module tb_seq_multiplier;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [7:0]  a, b;
  logic        ready, busy, done;
  logic [15:0] p;

  logic         start64;
  logic [63:0]  a64, b64;
  logic         ready64, busy64, done64;
  logic [127:0] p64;

  int checks = 0;
  int errors = 0;

  seq_multiplier #(.width(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .A(a), .B(b),
    .ready(ready), .busy(busy), .done(done), .P(p)
  );

  seq_multiplier #(.width(64)) dut64 (
    .clk(clk), .rst_n(rst_n), .start(start64), .A(a64), .B(b64),
    .ready(ready64), .busy(busy64), .done(done64), .P(p64)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called at the negedge after the start edge; returns edges from start to done.
  task automatic wait_done(output int cyc, output int bcnt);
    cyc  = 1;
    bcnt = busy ? 1 : 0;
    while (!done && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (busy) bcnt++;
    end
  endtask

  task automatic run_op(input string tag, input logic [7:0] x, input logic [7:0] y,
                        input logic [15:0] exp);
    int cyc, bcnt;
    @(negedge clk);
    a = x; b = y; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(cyc, bcnt);
    check({tag, "_latency"}, 128'(cyc), 128'(9));
    check({tag, "_busycycles"}, 128'(bcnt), 128'(8));
    check({tag, "_done"}, 128'(done), 128'(1));
    check({tag, "_p"}, 128'(p), 128'(exp));
    @(negedge clk);
    check({tag, "_done_drop"}, 128'(done), 128'(0));
    check({tag, "_ready_idle"}, 128'(ready), 128'(1));
    check({tag, "_p_hold"}, 128'(p), 128'(exp));
  endtask

  initial begin
    int cyc, bcnt, dones;
    logic [15:0] pdone;

    rst_n = 1'b0; start = 1'b1; a = 8'd1; b = 8'd1;
    start64 = 1'b0; a64 = '0; b64 = '0;
    repeat (3) @(negedge clk);
    check("rst_p", 128'(p), 128'(0));
    check("rst_ready", 128'(ready), 128'(1));
    check("rst_busy", 128'(busy), 128'(0));
    check("rst_done", 128'(done), 128'(0));
    check("rst_p64", p64, 128'(0));
    start = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_busy", 128'(busy), 128'(0));

    run_op("m13x11", 8'd13, 8'd11, 16'd143);
    run_op("m255x255", 8'd255, 8'd255, 16'hFE01);
    run_op("m0x200", 8'd0, 8'd200, 16'd0);
    run_op("m200x0", 8'd200, 8'd0, 16'd0);

    // Start while busy must be ignored.
    @(negedge clk);
    a = 8'd7; b = 8'd9; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    a = 8'd3; b = 8'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    dones = 0;
    pdone = '0;
    for (int i = 0; i < 20; i++) begin
      if (done) begin
        dones++;
        pdone = p;
      end
      @(negedge clk);
    end
    check("ign_dones", 128'(dones), 128'(1));
    check("ign_p_done", 128'(pdone), 128'(63));
    check("ign_p_hold", 128'(p), 128'(63));

    // Reset during iteration 4 discards the operation.
    @(negedge clk);
    a = 8'd100; b = 8'd100; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_rst_p", 128'(p), 128'(0));
    check("mid_rst_busy", 128'(busy), 128'(0));
    check("mid_rst_done", 128'(done), 128'(0));
    check("mid_rst_ready", 128'(ready), 128'(1));
    rst_n = 1'b1;
    run_op("m5x6", 8'd5, 8'd6, 16'd30);

    // Back-to-back: restart in the DONE cycle.
    @(negedge clk);
    a = 8'd12; b = 8'd12; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(cyc, bcnt);
    check("b2b1_latency", 128'(cyc), 128'(9));
    check("b2b1_p", 128'(p), 128'(144));
    a = 8'd9; b = 8'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("b2b_no_idle_busy", 128'(busy), 128'(1));
    check("b2b_no_idle_ready", 128'(ready), 128'(0));
    wait_done(cyc, bcnt);
    check("b2b2_latency", 128'(cyc), 128'(9));
    check("b2b2_done", 128'(done), 128'(1));
    check("b2b2_p", 128'(p), 128'(63));

    // Full-width 64-bit product.
    @(negedge clk);
    a64 = 64'hFFFF_FFFF_FFFF_FFFF; b64 = 64'hFFFF_FFFF_FFFF_FFFF; start64 = 1'b1;
    @(negedge clk);
    start64 = 1'b0;
    cyc = 1;
    while (!done64 && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    check("w64_latency", 128'(cyc), 128'(65));
    check("w64_p", p64, 128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
